// File: rtl/ring_pkg.sv
// Shared definitions for the ring TX arbiter: packet field positions and FSM encoding.
package ring_pkg;

    // Ring node address width; DST and SRC fields sit just below the FULL/ACK flags.
    localparam int ABITS = 3;

    function automatic int full_pos(input int width);
        return width - 1;
    endfunction

    function automatic int ack_pos(input int width);
        return width - 2;
    endfunction

    function automatic int dst_lsb(input int width);
        return width - 2 - ABITS;
    endfunction

    function automatic int src_lsb(input int width);
        return width - 2 - 2 * ABITS;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request scanning last+1, last+2, ... mod N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last) + k;
            if (j >= N) j = j - N;
            if (!any && req[j[IW-1:0]]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ring_tx_arbiter.sv
// Round-robin arbiter sharing the ring node TX FIFO write port among N requesters,
// with bounded bursts when other requesters are waiting.
module ring_tx_arbiter
    import ring_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    parameter  int BURST = 4,
    localparam int IW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
    input  logic [N-1:0]         req_en,
    output logic [WIDTH-1:0]     fifo_d,
    output logic                 fifo_wr,
    input  logic                 fifo_full,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_id,
    output logic                 stall
);

    localparam int         FULL_BIT = full_pos(WIDTH);
    localparam int         ACK_BIT  = ack_pos(WIDTH);
    localparam logic [3:0] BURST_L  = 4'(BURST);

    arb_state_e  state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] last, last_nx;
    logic [3:0]    cnt, cnt_nx;

    logic [N-1:0][WIDTH-1:0] lane_data;
    logic [N-1:0]            own_oh;
    logic [N-1:0]            cand;
    logic                    hold, own_valid, own_en, transfer, others;
    logic                    pick_any;
    logic [IW-1:0]           pick_idx;
    logic [3:0]              cnt_inc;

    assign lane_data = req_data;
    assign cand      = req_valid & req_en;
    assign hold      = (state == ST_HOLD);
    assign own_valid = req_valid[owner];
    assign own_en    = req_en[owner];
    assign transfer  = hold && own_valid && own_en && !fifo_full;
    assign others    = |(cand & ~own_oh);
    assign cnt_inc   = cnt + 4'd1;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign own_oh[i]    = (owner == IW'(i));
        assign req_ready[i] = hold && own_oh[i] && req_en[i] && !fifo_full;
    end

    rr_pick #(.N(N)) u_pick (
        .req  (cand),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= IW'(N - 1);
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx = ST_HOLD;
                    owner_nx = pick_idx;
                    cnt_nx   = '0;
                end
            end
            ST_HOLD: begin
                if (transfer) begin
                    if (cnt_inc == BURST_L) begin
                        // Burst exhausted: yield only if someone else is waiting.
                        cnt_nx = '0;
                        if (others) begin
                            state_nx = ST_IDLE;
                            last_nx  = owner;
                        end
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else if (!own_valid || !own_en) begin
                    state_nx = ST_IDLE;
                    last_nx  = owner;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_d = '0;
        if (hold) begin
            fifo_d           = lane_data[owner];
            fifo_d[FULL_BIT] = 1'b1;
            fifo_d[ACK_BIT]  = 1'b0;
        end
    end

    assign fifo_wr     = transfer;
    assign grant_valid = hold;
    assign grant_id    = owner;
    assign stall       = hold && own_valid && fifo_full;

endmodule

// File: tb/tb_ring_tx_arbiter.sv
// Directed vector bench for ring_tx_arbiter (N=4, WIDTH=16, BURST=4).
module tb_ring_tx_arbiter;

    localparam int N = 4;
    localparam int WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N*WIDTH-1:0]   req_data;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         req_en;
    logic [WIDTH-1:0]     fifo_d;
    logic                 fifo_wr;
    logic                 fifo_full;
    logic                 grant_valid;
    logic [1:0]           grant_id;
    logic                 stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_tx_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_en(req_en), .fifo_d(fifo_d), .fifo_wr(fifo_wr),
        .fifo_full(fifo_full), .grant_valid(grant_valid), .grant_id(grant_id), .stall(stall)
    );

    // Formatted words: lane0 0123->8123, lane1 4567->8567, lane2 C9AB->89AB, lane3 7FFF->BFFF
    localparam logic [15:0] D0 = 16'h8123;
    localparam logic [15:0] D1 = 16'h8567;
    localparam logic [15:0] D2 = 16'h89AB;
    localparam logic [15:0] D3 = 16'hBFFF;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  en;
        logic        full;
        logic        wr;
        logic [15:0] d;
        logic        gv;
        logic [1:0]  gid;
        logic [3:0]  rdy;
        logic        st;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] v, en, input logic full,
                                input logic wr, input logic [15:0] d, input logic gv,
                                input logic [1:0] gid, input logic [3:0] rdy, input logic st);
        vec_t x;
        x.rst = r; x.v = v; x.en = en; x.full = full;
        x.wr = wr; x.d = d; x.gv = gv; x.gid = gid; x.rdy = rdy; x.st = st;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs at the falling edge, then advance past the rising edge.
    task automatic cyc(input string tag, input logic r, input logic [3:0] v, en, input logic full,
                       input logic wr, input logic [15:0] d, input logic gv,
                       input logic [1:0] gid, input logic [3:0] rdy, input logic st);
        rst = r; req_valid = v; req_en = en; fifo_full = full;
        @(negedge clk);
        chk({tag, ".fifo_wr"}, 32'(fifo_wr), 32'(wr));
        chk({tag, ".fifo_d"}, 32'(fifo_d), 32'(d));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".stall"}, 32'(stall), 32'(st));
        @(posedge clk); #1;
    endtask

    initial begin
        // Single packet from requester 0
        add(1, 4'b0001, 4'hF, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        add(1, 4'b0001, 4'hF, 0, 1, D0,    1, 0, 4'b0001, 0);
        add(1, 4'b0000, 4'hF, 0, 0, D0,    1, 0, 4'b0001, 0);
        add(1, 4'b0000, 4'hF, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        // Requesters 0 and 2 contending: 2 wins first (last=0), bursts of 4, one-cycle gaps
        add(1, 4'b0101, 4'hF, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        repeat (4) add(1, 4'b0101, 4'hF, 0, 1, D2, 1, 2, 4'b0100, 0);
        add(1, 4'b0101, 4'hF, 0, 0, 16'h0, 0, 2, 4'b0000, 0);
        repeat (4) add(1, 4'b0101, 4'hF, 0, 1, D0, 1, 0, 4'b0001, 0);
        add(1, 4'b0101, 4'hF, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        add(1, 4'b0101, 4'hF, 0, 1, D2,    1, 2, 4'b0100, 0);
        add(1, 4'b0000, 4'hF, 0, 0, D2,    1, 2, 4'b0100, 0);
        add(1, 4'b0000, 4'hF, 0, 0, 16'h0, 0, 2, 4'b0000, 0);
        // Lone requester 1: ten back-to-back writes, grant kept across burst boundaries
        add(1, 4'b0010, 4'hF, 0, 0, 16'h0, 0, 2, 4'b0000, 0);
        repeat (10) add(1, 4'b0010, 4'hF, 0, 1, D1, 1, 1, 4'b0010, 0);
        add(1, 4'b0000, 4'hF, 0, 0, D1,    1, 1, 4'b0010, 0);
        add(1, 4'b0000, 4'hF, 0, 0, 16'h0, 0, 1, 4'b0000, 0);

        rst = 1'b0; req_valid = '0; req_en = 4'hF; fifo_full = 1'b0;
        req_data = {16'h7FFF, 16'hC9AB, 16'h4567, 16'h0123};
        repeat (2) @(posedge clk);
        #1;
        chk("reset.grant_valid", 32'(grant_valid), 0);
        chk("reset.grant_id", 32'(grant_id), 0);
        chk("reset.fifo_wr", 32'(fifo_wr), 0);
        chk("reset.fifo_d", 32'(fifo_d), 0);
        chk("reset.req_ready", 32'(req_ready), 0);
        chk("reset.stall", 32'(stall), 0);
        chk("reset.last", 32'(dut.last), 3);
        chk("reset.cnt", 32'(dut.cnt), 0);

        foreach (vecs[i])
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].v, vecs[i].en, vecs[i].full,
                vecs[i].wr, vecs[i].d, vecs[i].gv, vecs[i].gid, vecs[i].rdy, vecs[i].st);

        // fifo_full for 3 cycles mid-burst (last=1, so requester 0 is picked)
        cyc("full.idle", 1, 4'b0001, 4'hF, 0, 0, 16'h0, 0, 1, 4'b0000, 0);
        cyc("full.w0",   1, 4'b0001, 4'hF, 0, 1, D0,    1, 0, 4'b0001, 0);
        cyc("full.w1",   1, 4'b0001, 4'hF, 0, 1, D0,    1, 0, 4'b0001, 0);
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("full.blk%0d", k), 1, 4'b0001, 4'hF, 1, 0, D0, 1, 0, 4'b0000, 1);
            chk($sformatf("full.cnt%0d", k), 32'(dut.cnt), 2);
        end
        cyc("full.resume", 1, 4'b0001, 4'hF, 0, 1, D0, 1, 0, 4'b0001, 0);
        chk("full.cnt_after", 32'(dut.cnt), 3);
        cyc("full.rel",  1, 4'b0000, 4'hF, 0, 0, D0,    1, 0, 4'b0001, 0);

        // Disabled requester 3 is never granted until enabled
        for (int k = 0; k < 4; k++)
            cyc($sformatf("mask.off%0d", k), 1, 4'b1000, 4'b0111, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        cyc("mask.on",   1, 4'b1000, 4'hF, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        cyc("mask.gnt",  1, 4'b1000, 4'hF, 0, 1, D3,    1, 3, 4'b1000, 0);
        cyc("mask.rel",  1, 4'b0000, 4'hF, 0, 0, D3,    1, 3, 4'b1000, 0);
        cyc("mask.idle", 1, 4'b0000, 4'hF, 0, 0, 16'h0, 0, 3, 4'b0000, 0);

        // Reset during HOLD with cnt=2; transfer on the reset edge still writes
        cyc("rst.idle", 1, 4'b0010, 4'hF, 0, 0, 16'h0, 0, 3, 4'b0000, 0);
        cyc("rst.w0",   1, 4'b0010, 4'hF, 0, 1, D1,    1, 1, 4'b0010, 0);
        cyc("rst.w1",   1, 4'b0010, 4'hF, 0, 1, D1,    1, 1, 4'b0010, 0);
        chk("rst.cnt_before", 32'(dut.cnt), 2);
        cyc("rst.edge", 0, 4'b0011, 4'hF, 0, 1, D1,    1, 1, 4'b0010, 0);
        chk("rst.last", 32'(dut.last), 3);
        chk("rst.cnt", 32'(dut.cnt), 0);
        cyc("rst.after", 1, 4'b0011, 4'hF, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        cyc("rst.gnt0",  1, 4'b0011, 4'hF, 0, 1, D0,    1, 0, 4'b0001, 0);

        // Clearing the owner's enable blocks the transfer at once and releases next edge
        cyc("en.clr",  1, 4'b0011, 4'b1110, 0, 0, D0,    1, 0, 4'b0000, 0);
        cyc("en.idle", 1, 4'b0011, 4'b1110, 0, 0, 16'h0, 0, 0, 4'b0000, 0);
        cyc("en.gnt1", 1, 4'b0011, 4'b1110, 0, 1, D1,    1, 1, 4'b0010, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_tx_arbiter.md
# ring_tx_arbiter

Round-robin arbiter that shares one ring node's transmit FIFO write port among N local requesters. Each requester offers 16-bit ring packets on a valid/ready interface. The arbiter grants one requester at a time, with a bounded burst length. It formats granted words as payload packets and writes them into the node's TX FIFO. It sits between local client logic and the ring node's TX FIFO, alongside the SPI client path.

## Interface
- N, 4: number of requesters, 2..8
- WIDTH, 16: packet width, matches ring width
- BURST, 4: maximum consecutive packets per grant when other requesters are waiting, 1..15
- IW, $clog2(N): width of the grant index (derived, not overridden)

Ports:
- clk  input  1  single system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low: rst=0 at a clk edge resets all state
- req_valid  input  N  requester i offers a packet
- req_data  input  N*WIDTH  packet of requester i in bits [i*WIDTH +: WIDTH]
- req_ready  output  N  packet of requester i accepted this cycle when valid&ready
- req_en  input  N  enable mask; a disabled requester is never granted
- fifo_d  output  WIDTH  data to TX FIFO
- fifo_wr  output  1  TX FIFO write strobe
- fifo_full  input  1  TX FIFO full
- grant_valid  output  1  an owner currently holds the grant
- grant_id  output  IW  current owner index
- stall  output  1  owner has valid data but fifo_full blocks it

## Operation
- States: IDLE (no owner) and HOLD (owner, burst count cnt, 4 bits).
- Round-robin pointer last (IW bits) holds the most recently released owner.
- IDLE: candidates = req_valid & req_en. If any candidate exists, pick the first one scanning last+1, last+2, … mod N. Next cycle: HOLD, owner = pick, cnt = 0. No transfer occurs in IDLE.
- HOLD: transfer = req_valid[owner] & req_en[owner] & ~fifo_full. On a transfer, cnt increments.
- HOLD → IDLE with last = owner when either condition holds:
  - req_valid[owner]=0 or req_en[owner]=0 in a cycle with no transfer.
  - A transfer makes cnt reach BURST while any other enabled requester is valid.
- Transfer reaches BURST with no other candidate: cnt reloads 0 and the owner keeps the grant.
- fifo_full in HOLD: no transfer; owner and cnt are held; stall=1 if req_valid[owner].
- req_ready[i] = (state==HOLD) & (owner==i) & req_en[i] & ~fifo_full. This is combinational from state and fifo_full.
- fifo_wr = transfer, combinational.
- fifo_d = req_data[owner] with bit WIDTH-1 (FULL) forced to 1 and bit WIDTH-2 (ACK) forced to 0. All other bits pass unchanged; the node inserts the SRC field.
- Masking requester i by clearing req_en[i] mid-grant takes effect in the same cycle: no transfer. The owner is released next edge.

## Timing
- Reset (rst=0): state IDLE, last=N-1 (requester 0 has first priority), cnt=0, grant_id=0, grant_valid=0.
- Outputs after reset: req_ready=0, fifo_wr=0, stall=0, fifo_d=0 (fifo_d is forced 0 when not in HOLD).
- Grant latency: a request arriving at an idle arbiter is accepted 1 cycle after its first valid cycle.
- Sustained throughput: 1 packet/cycle per owner.
- Rotation cost: 2 cycles (one IDLE cycle) between the last packet of one owner and the first of the next.
- Reset asserted mid-burst drops the grant. A packet whose transfer cycle coincides with the reset edge is written: fifo_wr is combinational. The requester sees it accepted.

## Structure
- Shared package ring_pkg holds:
  - Bit positions FULL=WIDTH-1 and ACK=WIDTH-2.
  - DST/SRC field offsets for ABITS.
  - The IDLE/HOLD state encoding.
- One sub-module, rr_pick: a combinational rotating priority encoder (inputs: request vector, last; outputs: any, index). It is instantiated once.

## Test plan
- Reset, then requester 0 valid with data 16'h0123 → fifo_wr one cycle after the valid edge, fifo_d=16'h8123, grant_id=0.
- Requesters 0 and 2 continuously valid, BURST=4 → writes follow the pattern 0,0,0,0,gap,2,2,2,2,gap,0…; each gap is exactly 1 cycle.
- Only requester 1 valid for 10 packets, BURST=4 → 10 back-to-back writes with no gap; grant never released.
- fifo_full held high for 3 cycles mid-burst → fifo_wr=0, stall=1, req_ready=0, cnt unchanged; resumes on the cycle fifo_full drops.
- req_en[3]=0 with req_valid[3]=1, others idle → no grant ever; then req_en[3]=1 → grant_id=3 one cycle later.
- rst=0 during HOLD with cnt=2 → next cycle grant_valid=0, last=N-1; requesters 0 and 1 both valid afterwards → requester 0 is granted first.
